frame_load_ctrl: RTL and testbench
==================================

FRAME_LOAD_CTRL -- requirements
Module: frame_load_ctrl

Interface
REQ-001 The block SHALL have parameter MaxFramesPerCol, default 20: number of frame strobes driven, legal range 1..32.
REQ-002 The block SHALL have parameter FrameBitsPerRow, default 32: frame data width, equal to the word width.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port WriteData, input, FrameBitsPerRow bits: the incoming header or data word.
REQ-006 The block SHALL have port WriteValid, input, 1 bit: WriteData is valid this cycle.
REQ-007 The block SHALL have port WriteReady, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have port FrameData, output, FrameBitsPerRow bits: the registered frame word driven to the column config latches.
REQ-009 The block SHALL have port FrameStrobe, output, MaxFramesPerCol bits: one-hot latch enables.
REQ-010 The block SHALL have port Busy, output, 1 bit: a frame sequence is in progress.
REQ-011 The block SHALL have port Done, output, 1 bit: one-cycle pulse after the last frame strobe of a sequence.
REQ-012 The block SHALL have port Error, output, 1 bit: sticky flag marking a rejected header.
REQ-013 The block SHALL have port Checksum, output, 32 bits: running XOR of committed data words.

Function
REQ-014 A transfer SHALL occur on any rising edge where WriteValid and WriteReady are both high.
REQ-015 The state machine SHALL have three states: IDLE, LOAD and STROBE.
REQ-016 In IDLE and LOAD, WriteReady SHALL be 1; in STROBE, WriteReady SHALL be 0.
REQ-017 In IDLE, a transferred word SHALL be treated as a header with these fields: marker [31:24], count-1 [12:8], start index [4:0].
REQ-018 A header SHALL be valid only if marker equals 8'hFA and start + count is less than or equal to MaxFramesPerCol.
REQ-019 On a valid header the block SHALL: load the index register with start, load the remaining counter with count, clear Error, clear Checksum, and move to LOAD.
REQ-020 On an invalid header the block SHALL: consume the word, set Error, and stay in IDLE.
REQ-021 In LOAD, a transferred word SHALL be registered into FrameData on that edge, and the state SHALL move to STROBE.
REQ-022 In STROBE, FrameStrobe[index] SHALL be 1 for exactly that one cycle, with FrameData stable; all other strobe bits SHALL be 0.
REQ-023 On leaving STROBE, the index SHALL increment and the remaining counter SHALL decrement.
REQ-024 On leaving STROBE, if the remaining counter was 1, the state SHALL move to IDLE and Done SHALL pulse high for the following cycle; otherwise the state SHALL move to LOAD.
REQ-025 Latency SHALL be exactly 1 cycle from data-word acceptance to strobe; peak throughput SHALL be one frame per 2 cycles.
REQ-026 FrameData SHALL hold its last value outside of LOAD transfers.
REQ-027 FrameStrobe SHALL be all-zero in every state except STROBE.
REQ-028 Busy SHALL be 1 in LOAD and STROBE, and 0 in IDLE.
REQ-029 WriteValid low while in LOAD SHALL stall the sequence indefinitely, with no strobe and no timeout.
REQ-030 Count field 31 (32 frames) SHALL be legal only when MaxFramesPerCol is 32.

Reset
REQ-031 Assertion of resetn low SHALL immediately force: state IDLE, FrameStrobe 0, FrameData 0, index 0, counter 0, Busy 0, Done 0, Error 0, Checksum 0.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence with no further strobe; the next word after release SHALL be parsed as a header.
REQ-033 Reset release SHALL take effect on the first rising edge of CLK with resetn high.

Configuration
REQ-034 Macro FRAME_LOAD_CHECKSUM_EN SHALL control the checksum feature.
REQ-035 With FRAME_LOAD_CHECKSUM_EN defined, Checksum SHALL XOR in FrameData (zero-extended to 32 bits) on each STROBE cycle, and SHALL be cleared on a valid header and on reset.
REQ-036 Without FRAME_LOAD_CHECKSUM_EN defined, Checksum SHALL be a constant 0, no checksum register SHALL be built, and all other behaviour SHALL be identical.

Verification
REQ-037 Reset, then send header 32'hFA00_0100 followed by data words 32'h1234_5678 and 32'hCAFE_F00D -> FrameStrobe = 20'h00001 with FrameData = 32'h1234_5678, then 20'h00002 with FrameData = 32'hCAFE_F00D, each strobe 1 cycle, each strobe 1 cycle after acceptance; Done pulses once; Checksum = 32'hD8CA_A675 (macro on).
REQ-038 Send header 32'hFA00_0013 (start 19, count 1) -> a single strobe on FrameStrobe[19]; send header 32'hFA00_0114 (start 20) -> Error = 1, no strobe, state stays IDLE.
REQ-039 Send header 32'h0000_0000 (bad marker) -> Error = 1; then a valid header -> Error clears.
REQ-040 Hold WriteValid high continuously during a 4-frame sequence -> WriteReady toggles 1,0 each cycle; exactly 4 strobes occur on consecutive odd cycles.
REQ-041 Assert resetn low during the STROBE cycle of frame 2 of 3 -> FrameStrobe drops to 0 immediately; after release, no strobe occurs until a new valid header and data word arrive.
REQ-042 With the macro off, repeat REQ-037 -> identical strobes and data, and Checksum stays 0 throughout.

Source files
------------

// File: rtl/frame_load_ctrl_if.sv
// Write-side handshake and frame-latch bus for frame_load_ctrl.
// master: the word source (drives WriteData/WriteValid, observes the rest).
// slave : the frame load controller.
interface frame_load_ctrl_if #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32
);
  logic [FrameBitsPerRow-1:0] WriteData;
  logic                       WriteValid;
  logic                       WriteReady;
  logic [FrameBitsPerRow-1:0] FrameData;
  logic [MaxFramesPerCol-1:0] FrameStrobe;
  logic                       Busy;
  logic                       Done;
  logic                       Error;
  logic [31:0]                Checksum;

  modport master (
    output WriteData, WriteValid,
    input  WriteReady, FrameData, FrameStrobe, Busy, Done, Error, Checksum
  );

  modport slave (
    input  WriteData, WriteValid,
    output WriteReady, FrameData, FrameStrobe, Busy, Done, Error, Checksum
  );
endinterface

// File: rtl/frame_load_ctrl.sv
// frame_load_ctrl: parses a header word, then latches each following data word
// and pulses a one-hot strobe to the matching column config latch.
// Optional feature: define FRAME_LOAD_CHECKSUM_EN to build a running XOR of the
// strobed words on Checksum; otherwise Checksum is tied to 0.
module frame_load_ctrl #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32
) (
  input  logic                CLK,
  input  logic                resetn,
  frame_load_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STROBE = 2'd2} state_t;

  localparam logic [6:0] MaxFrames7 = 7'(MaxFramesPerCol);

  state_t                     state_q, state_d;
  logic [5:0]                 index_q, index_d;
  logic [5:0]                 remain_q, remain_d;
  logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
  logic                       error_q, error_d;
  logic                       done_q, done_d;
  logic                       ready;

  // Header fields: marker [31:24], count-1 [12:8], start [4:0]
  logic [7:0] hdr_marker;
  logic [5:0] hdr_start;
  logic [5:0] hdr_count;
  logic [6:0] hdr_end;
  logic       hdr_valid;
  logic       hdr_accept;
  logic       unused_hdr_bits;

  assign hdr_marker = bus.WriteData[31:24];
  assign hdr_start  = {1'b0, bus.WriteData[4:0]};
  assign hdr_count  = {1'b0, bus.WriteData[12:8]} + 6'd1;
  assign hdr_end    = {1'b0, hdr_start} + {1'b0, hdr_count};
  assign hdr_valid  = (hdr_marker == 8'hFA) && (hdr_end <= MaxFrames7);
  assign hdr_accept = (state_q == IDLE) && bus.WriteValid && hdr_valid;
  assign unused_hdr_bits = ^{bus.WriteData[23:13], bus.WriteData[7:5]};

  // Next-state, datapath updates and handshake for the three-state sequencer
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    remain_d     = remain_q;
    frame_data_d = frame_data_q;
    error_d      = error_q;
    done_d       = 1'b0;
    ready        = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.WriteValid) begin
          if (hdr_valid) begin
            index_d  = hdr_start;
            remain_d = hdr_count;
            error_d  = 1'b0;
            state_d  = LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      LOAD: begin
        ready = 1'b1;
        if (bus.WriteValid) begin
          frame_data_d = bus.WriteData;
          state_d      = STROBE;
        end
      end
      STROBE: begin
        index_d  = index_q + 6'd1;
        remain_d = remain_q - 6'd1;
        if (remain_q == 6'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by resetn
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      index_q      <= '0;
      remain_q     <= '0;
      frame_data_q <= '0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      remain_q     <= remain_d;
      frame_data_q <= frame_data_d;
      error_q      <= error_d;
      done_q       <= done_d;
    end
  end

  // One-hot strobe decode: only the addressed latch fires, and only in STROBE
  logic [MaxFramesPerCol-1:0] strobe;
  for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : g_strobe
    assign strobe[gi] = (state_q == STROBE) && (index_q == 6'(gi));
  end

  assign bus.WriteReady  = ready;
  assign bus.FrameData   = frame_data_q;
  assign bus.FrameStrobe = strobe;
  assign bus.Busy        = (state_q != IDLE);
  assign bus.Done        = done_q;
  assign bus.Error       = error_q;

`ifdef FRAME_LOAD_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  // Restart on an accepted header, fold in the word on every strobe cycle
  always_comb begin
    checksum_d = checksum_q;
    if (hdr_accept) begin
      checksum_d = '0;
    end else if (state_q == STROBE) begin
      checksum_d = checksum_q ^ 32'(frame_data_q);
    end
  end

  // Checksum register
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign bus.Checksum = checksum_q;
`else
  logic unused_hdr_accept;
  assign unused_hdr_accept = hdr_accept;
  assign bus.Checksum      = 32'd0;
`endif

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Scoreboard bench for frame_load_ctrl: stimulus pushes expected strobes into a
// queue, a negedge monitor pops and compares whenever a strobe appears.
module tb_frame_load_ctrl;

  localparam int MAXF = 20;
  localparam int BITS = 32;

  typedef struct {
    logic [MAXF-1:0] strobe;
    logic [31:0]     data;
    int              cyc;
  } exp_t;

  logic CLK;
  logic resetn;
  int   checks;
  int   errors;
  int   cyc;
  int   done_cnt;
  exp_t exp_q[$];

  frame_load_ctrl_if #(.MaxFramesPerCol(MAXF), .FrameBitsPerRow(BITS)) bus ();

  frame_load_ctrl #(.MaxFramesPerCol(MAXF), .FrameBitsPerRow(BITS)) dut (
    .CLK   (CLK),
    .resetn(resetn),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every visible strobe must match the head of the expected queue
  always @(negedge CLK) begin
    if (resetn) begin
      if (bus.Done) done_cnt++;
      if (bus.FrameStrobe != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual=%0h required=none", bus.FrameStrobe);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_bits", 64'(bus.FrameStrobe), 64'(e.strobe));
          chk("strobe_data", 64'(bus.FrameData), 64'(e.data));
          chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
          chk("strobe_busy_ready", {62'd0, bus.Busy, bus.WriteReady}, 64'h2);
          $display("strobe bits=%0h data=%08h cycle=%0d", bus.FrameStrobe, bus.FrameData, cyc);
        end
      end
    end
  end

  // Present one word and hold it until the handshake completes
  task automatic send_word(input logic [31:0] w, output int waits, output int acc_cyc);
    int n;
    waits = 0;
    n = 0;
    acc_cyc = 0;
    bus.WriteValid = 1'b1;
    bus.WriteData  = w;
    forever begin
      @(negedge CLK);
      if (bus.WriteReady) begin
        acc_cyc = cyc + 1;
        break;
      end
      waits++;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout actual=ready_low required=ready_high word=%08h", w);
        break;
      end
    end
    @(posedge CLK);
    #1;
    $display("word %08h accepted cycle=%0d waits=%0d", w, acc_cyc, waits);
  endtask

  task automatic send_data(input logic [31:0] w, input int idx, input bit push, output int waits);
    int acc;
    exp_t e;
    send_word(w, waits, acc);
    if (push) begin
      e.strobe = MAXF'(1) << idx;
      e.data   = w;
      e.cyc    = acc;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_hdr(input logic [31:0] w);
    int waits;
    int acc;
    send_word(w, waits, acc);
  endtask

  task automatic idle(input int n);
    bus.WriteValid = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int w;
  int d0;
  logic [31:0] exp_ck;

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    done_cnt = 0;
    bus.WriteValid = 1'b0;
    bus.WriteData  = '0;
    resetn = 1'b0;
    #1;
    chk("reset_strobe", 64'(bus.FrameStrobe), 64'd0);
    chk("reset_data", 64'(bus.FrameData), 64'd0);
    chk("reset_flags", {61'd0, bus.Busy, bus.Done, bus.Error}, 64'd0);
    chk("reset_checksum", 64'(bus.Checksum), 64'd0);
    @(negedge CLK);
    resetn = 1'b1;
    idle(1);

    // Two frames from index 0
    d0 = done_cnt;
    send_hdr(32'hFA00_0100);
    chk("hdr_busy", {63'd0, bus.Busy}, 64'd1);
    send_data(32'h1234_5678, 0, 1'b1, w);
    send_data(32'hCAFE_F00D, 1, 1'b1, w);
    idle(3);
    chk("seq1_done_count", 64'(done_cnt - d0), 64'd1);
`ifdef FRAME_LOAD_CHECKSUM_EN
    exp_ck = 32'hD8CA_A675;
`else
    exp_ck = 32'h0;
`endif
    chk("seq1_checksum", 64'(bus.Checksum), 64'(exp_ck));
    chk("seq1_data_hold", 64'(bus.FrameData), 64'hCAFE_F00D);
    chk("seq1_idle_busy", {63'd0, bus.Busy}, 64'd0);

    // Last legal index, then out-of-range headers
    d0 = done_cnt;
    send_hdr(32'hFA00_0013);
    chk("hdr19_checksum_clear", 64'(bus.Checksum), 64'd0);
    send_data(32'hA5A5_0001, 19, 1'b1, w);
    idle(3);
    chk("seq19_done_count", 64'(done_cnt - d0), 64'd1);
    send_hdr(32'hFA00_0114);
    chk("hdr_start20_error", {62'd0, bus.Error, bus.Busy}, 64'h2);
    send_hdr(32'hFA00_0014);
    chk("hdr_end21_error", {62'd0, bus.Error, bus.Busy}, 64'h2);
    send_hdr(32'hFA00_1F00);
    chk("hdr_count32_error", {62'd0, bus.Error, bus.Busy}, 64'h2);
    idle(2);

    // Bad marker sets Error, valid header clears it
    send_hdr(32'h0000_0000);
    chk("bad_marker_error", {62'd0, bus.Error, bus.Busy}, 64'h2);
    send_hdr(32'hFA00_0000);
    chk("good_hdr_clears_error", {62'd0, bus.Error, bus.Busy}, 64'h1);
    send_data(32'h0000_BEEF, 0, 1'b1, w);
    idle(3);

    // Back-to-back four frames from index 5 with WriteValid held high
    d0 = done_cnt;
    send_hdr(32'hFA00_0305);
    send_data(32'h1111_1111, 5, 1'b1, w);
    chk("b2b_first_waits", 64'(w), 64'd0);
    send_data(32'h2222_2222, 6, 1'b1, w);
    chk("b2b_waits_2", 64'(w), 64'd1);
    send_data(32'h3333_3333, 7, 1'b1, w);
    chk("b2b_waits_3", 64'(w), 64'd1);
    send_data(32'h4444_4444, 8, 1'b1, w);
    chk("b2b_waits_4", 64'(w), 64'd1);
    idle(3);
    chk("b2b_done_count", 64'(done_cnt - d0), 64'd1);
`ifdef FRAME_LOAD_CHECKSUM_EN
    exp_ck = 32'h4444_4444;
`else
    exp_ck = 32'h0;
`endif
    chk("b2b_checksum", 64'(bus.Checksum), 64'(exp_ck));

    // Reset during the strobe of frame 2 of 3
    send_hdr(32'hFA00_0200);
    send_data(32'h0000_00D1, 0, 1'b1, w);
    send_data(32'h0000_00D2, 1, 1'b0, w);
    resetn = 1'b0;
    #1;
    chk("rst_mid_strobe", 64'(bus.FrameStrobe), 64'd0);
    chk("rst_mid_data", 64'(bus.FrameData), 64'd0);
    chk("rst_mid_flags", {61'd0, bus.Busy, bus.Done, bus.Error}, 64'd0);
    chk("rst_mid_checksum", 64'(bus.Checksum), 64'd0);
    bus.WriteValid = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    d0 = done_cnt;
    idle(4);
    send_hdr(32'h5555_5555);
    chk("post_rst_word_is_header", {62'd0, bus.Error, bus.Busy}, 64'h2);
    idle(2);
    chk("post_rst_no_done", 64'(done_cnt - d0), 64'd0);
    send_hdr(32'hFA00_0002);
    send_data(32'h0000_00D3, 2, 1'b1, w);
    idle(3);
    chk("post_rst_done_count", 64'(done_cnt - d0), 64'd1);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
